jtopl_slot_seq: RTL and testbench

Slot scheduler for the OPL operator pipeline. It divides the master clock enable into the operator-rate enable (cenop) and rotates the 18-slot one-hot sequence that the phase generator, envelope generator and rhythm logic consume. It also decodes channel/operator indices, generates per-operator phase-reset requests from key-on edges, and runs the vibrato step counter. It sits between the register file and the phase generator: it drives their slot, cenop, pg_rst and vib_cnt inputs.

---
 rtl/jtopl_pkg.sv | 39 +++
 rtl/jtopl_slot_dec.sv | 25 ++
 rtl/jtopl_slot_seq.sv | 111 +++++++++++
 tb/tb_jtopl_slot_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | jtopl_pkg: slot/channel geometry and slot-to-operator decode helpers    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package jtopl_pkg;

  localparam int SLOTS     = 18;
  localparam int CHANNELS  = 9;
  localparam int SLOT_W    = 5;
  localparam int CH_W      = 4;
  localparam int VIB_CNT_W = 3;

  typedef enum logic {
    OP_MOD = 1'b0,
    OP_CAR = 1'b1
  } op_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    op_e             op;
  } slot_info_t;

  // Slots come in groups of six: three modulators then the three matching carriers.
  function automatic slot_info_t slot_decode(input logic [SLOT_W-1:0] s);
    slot_info_t   info;
    logic [SLOT_W-1:0] g;
    logic [SLOT_W-1:0] r;
    logic [SLOT_W-1:0] rm;
    g       = s / 5'd6;
    r       = s % 5'd6;
    rm      = (r >= 5'd3) ? (r - 5'd3) : r;
    info.op = (r >= 5'd3) ? OP_CAR : OP_MOD;
    info.ch = CH_W'(g * 5'd3 + rm);
    return info;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtopl_slot_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | jtopl_slot_dec: slot index -> one-hot slot, channel and operator        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module jtopl_slot_dec
  import jtopl_pkg::*;
(
  input  logic [SLOT_W-1:0] i_s,
  output logic [SLOTS-1:0]  o_slot,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_op
);

  slot_info_t w_info;

  always_comb begin
    w_info = slot_decode(i_s);
    o_slot = SLOTS'(1) << i_s;
    o_ch   = w_info.ch;
    o_op   = w_info.op;
  end

endmodule
`default_nettype wire

// File: rtl/jtopl_slot_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | jtopl_slot_seq: operator-rate enable, 18-slot rotation, key-on phase   |
// | resets and vibrato step counter. Rev 1.0                              |
// +-----------------------------------------------------------------------+
module jtopl_slot_seq
  import jtopl_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int VIB_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [CHANNELS-1:0]  keyon,
  output logic                 cenop,
  output logic [SLOTS-1:0]     slot,
  output logic [CH_W-1:0]      ch,
  output logic                 op,
  output logic                 zero,
  output logic                 pg_rst,
  output logic [VIB_CNT_W-1:0] vib_cnt
);

  localparam logic [3:0]        c_DIV_LAST  = 4'(DIV - 1);
  localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(SLOTS - 1);

  logic [3:0]           r_div;
  logic [SLOT_W-1:0]    r_s;
  logic [CHANNELS-1:0]  r_kon;
  logic [VIB_W-1:0]     r_smp;
  logic [VIB_CNT_W-1:0] r_vib;
  logic                 r_cenop;
  logic [SLOTS-1:0]     r_slot;
  logic [CH_W-1:0]      r_ch;
  logic                 r_op;
  logic                 r_zero;
  logic                 r_pg_rst;

  logic                 w_tick;
  logic                 w_wrap;
  logic [SLOT_W-1:0]    w_s_next;
  logic [SLOTS-1:0]     w_slot;
  logic [CH_W-1:0]      w_ch;
  logic                 w_op;
  logic                 w_kon_cur;
  logic                 w_kon_old;

  assign w_tick    = cen & (r_div == c_DIV_LAST);
  assign w_wrap    = (r_s == c_SLOT_LAST);
  assign w_s_next  = w_wrap ? '0 : (r_s + 5'd1);
  assign w_kon_cur = keyon[w_ch];
  assign w_kon_old = r_kon[w_ch];

  // Decode the slot being entered so every output moves on the cenop clk.
  jtopl_slot_dec u_dec (
    .i_s    (w_s_next),
    .o_slot (w_slot),
    .o_ch   (w_ch),
    .o_op   (w_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_s      <= '0;
      r_kon    <= '0;
      r_smp    <= '0;
      r_vib    <= '0;
      r_cenop  <= 1'b0;
      r_slot   <= SLOTS'(1);
      r_ch     <= '0;
      r_op     <= 1'b0;
      r_zero   <= 1'b1;
      r_pg_rst <= 1'b0;
    end else begin
      r_cenop <= w_tick;
      if (cen) begin
        r_div <= (r_div == c_DIV_LAST) ? 4'd0 : (r_div + 4'd1);
      end
      if (w_tick) begin
        r_s      <= w_s_next;
        r_slot   <= w_slot;
        r_ch     <= w_ch;
        r_op     <= w_op;
        r_zero   <= (w_s_next == '0);
        r_pg_rst <= w_kon_cur & ~w_kon_old;
        // History only advances at the carrier, so the modulator sees the edge too.
        if (w_op) begin
          r_kon[w_ch] <= w_kon_cur;
        end
        if (w_wrap) begin
          r_smp <= r_smp + VIB_W'(1);
          if (&r_smp) begin
            r_vib <= r_vib + 3'd1;
          end
        end
      end
    end
  end

  assign cenop   = r_cenop;
  assign slot    = r_slot;
  assign ch      = r_ch;
  assign op      = r_op;
  assign zero    = r_zero;
  assign pg_rst  = r_pg_rst;
  assign vib_cnt = r_vib;

endmodule
`default_nettype wire

// File: tb/tb_jtopl_slot_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_jtopl_slot_seq: directed checks of slot rotation, pg_rst and vibrato |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_jtopl_slot_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: DIV=4; B: DIV=2 with gapped cen; C: DIV=1 long vibrato; D: DIV=1 short vibrato.
  logic        rst_a, cen_a, rst_b, cen_b, rst_c, cen_c, rst_d, cen_d;
  logic [8:0]  kon_a, kon_b, kon_c, kon_d;
  logic        a_cenop, b_cenop, c_cenop, d_cenop;
  logic [17:0] a_slot, b_slot, c_slot, d_slot;
  logic [3:0]  a_ch, b_ch, c_ch, d_ch;
  logic        a_op, b_op, c_op, d_op;
  logic        a_zero, b_zero, c_zero, d_zero;
  logic        a_pg, b_pg, c_pg, d_pg;
  logic [2:0]  a_vib, b_vib, c_vib, d_vib;

  jtopl_slot_seq #(.DIV(4), .VIB_W(10)) u_a (
    .clk(clk), .rst(rst_a), .cen(cen_a), .keyon(kon_a), .cenop(a_cenop), .slot(a_slot),
    .ch(a_ch), .op(a_op), .zero(a_zero), .pg_rst(a_pg), .vib_cnt(a_vib));
  jtopl_slot_seq #(.DIV(2), .VIB_W(10)) u_b (
    .clk(clk), .rst(rst_b), .cen(cen_b), .keyon(kon_b), .cenop(b_cenop), .slot(b_slot),
    .ch(b_ch), .op(b_op), .zero(b_zero), .pg_rst(b_pg), .vib_cnt(b_vib));
  jtopl_slot_seq #(.DIV(1), .VIB_W(10)) u_c (
    .clk(clk), .rst(rst_c), .cen(cen_c), .keyon(kon_c), .cenop(c_cenop), .slot(c_slot),
    .ch(c_ch), .op(c_op), .zero(c_zero), .pg_rst(c_pg), .vib_cnt(c_vib));
  jtopl_slot_seq #(.DIV(1), .VIB_W(2)) u_d (
    .clk(clk), .rst(rst_d), .cen(cen_d), .keyon(kon_d), .cenop(d_cenop), .slot(d_slot),
    .ch(d_ch), .op(d_op), .zero(d_zero), .pg_rst(d_pg), .vib_cnt(d_vib));

  int ch_tab [18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};
  int op_tab [18] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one frame of instance A (four clks per slot); pg_slots marks slots expecting pg_rst.
  task automatic a_frame(input logic [17:0] pg_slots);
    for (int n = 1; n <= 18; n++) begin
      int          s;
      logic [17:0] e_slot;
      logic [17:0] e_prev;
      s      = n % 18;
      e_slot = 18'd1 << s;
      e_prev = 18'd1 << (n - 1);
      ticks(3);
      chk("a_cenop_low", 32'(a_cenop), 32'd0);
      chk("a_slot_hold", 32'(a_slot), 32'(e_prev));
      tick();
      chk("a_cenop_high", 32'(a_cenop), 32'd1);
      chk("a_slot", 32'(a_slot), 32'(e_slot));
      chk("a_ch", 32'(a_ch), 32'(ch_tab[s]));
      chk("a_op", 32'(a_op), 32'(op_tab[s]));
      chk("a_zero", 32'(a_zero), (s == 0) ? 32'd1 : 32'd0);
      chk("a_pg_rst", 32'(a_pg), 32'(pg_slots[s]));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    cen_a = 1'b1; cen_b = 1'b0; cen_c = 1'b1; cen_d = 1'b1;
    kon_a = '0; kon_b = '0; kon_c = '0; kon_d = 9'b000100000;
    ticks(2);

    chk("rst_cenop", 32'(a_cenop), 32'd0);
    chk("rst_slot", 32'(a_slot), 32'h1);
    chk("rst_ch", 32'(a_ch), 32'd0);
    chk("rst_op", 32'(a_op), 32'd0);
    chk("rst_zero", 32'(a_zero), 32'd1);
    chk("rst_pg_rst", 32'(a_pg), 32'd0);
    chk("rst_vib", 32'(a_vib), 32'd0);

    // A: plain rotation, then a key-on edge on channel 4 (slots 7 and 10).
    rst_a = 1'b0;
    a_frame(18'h0);
    kon_a[4] = 1'b1;
    a_frame(18'h00480);
    a_frame(18'h0);
    chk("a_vib_after3", 32'(a_vib), 32'd0);

    // B: DIV=2 with cen pattern 1,0,0,1,1,0,1,0.
    rst_b = 1'b0;
    cen_b = 1'b1; tick();
    chk("b_e1_cenop", 32'(b_cenop), 32'd0);
    chk("b_e1_slot", 32'(b_slot), 32'h1);
    cen_b = 1'b0; tick();
    chk("b_e2_cenop", 32'(b_cenop), 32'd0);
    tick();
    chk("b_e3_cenop", 32'(b_cenop), 32'd0);
    chk("b_e3_slot", 32'(b_slot), 32'h1);
    cen_b = 1'b1; tick();
    chk("b_e4_cenop", 32'(b_cenop), 32'd1);
    chk("b_e4_slot", 32'(b_slot), 32'h2);
    chk("b_e4_zero", 32'(b_zero), 32'd0);
    tick();
    chk("b_e5_cenop", 32'(b_cenop), 32'd0);
    chk("b_e5_slot", 32'(b_slot), 32'h2);
    cen_b = 1'b0; tick();
    chk("b_e6_cenop", 32'(b_cenop), 32'd0);
    chk("b_e6_slot", 32'(b_slot), 32'h2);
    cen_b = 1'b1; tick();
    chk("b_e7_cenop", 32'(b_cenop), 32'd1);
    chk("b_e7_slot", 32'(b_slot), 32'h4);
    chk("b_e7_ch", 32'(b_ch), 32'd2);
    cen_b = 1'b0; tick();
    chk("b_e8_cenop", 32'(b_cenop), 32'd0);
    chk("b_e8_slot", 32'(b_slot), 32'h4);

    // C: VIB_W=10, vib_cnt steps on the wrap into frame 1024 (clk 18432).
    rst_c = 1'b0;
    ticks(18431);
    chk("c_vib_before", 32'(c_vib), 32'd0);
    chk("c_slot_17", 32'(c_slot), 32'h20000);
    tick();
    chk("c_vib_step", 32'(c_vib), 32'd1);
    chk("c_zero", 32'(c_zero), 32'd1);

    // D: VIB_W=2, so vib_cnt steps every 72 clks and wraps after 576.
    rst_d = 1'b0;
    ticks(71);
    chk("d_vib_71", 32'(d_vib), 32'd0);
    tick();
    chk("d_vib_72", 32'(d_vib), 32'd1);
    chk("d_slot_72", 32'(d_slot), 32'h1);
    ticks(575 - 72);
    chk("d_vib_575", 32'(d_vib), 32'd7);
    tick();
    chk("d_vib_wrap", 32'(d_vib), 32'd0);
    ticks(947 - 576);
    chk("d_vib_5", 32'(d_vib), 32'd5);
    chk("d_slot_11", 32'(d_slot), 32'h00800);
    rst_d = 1'b1; tick();
    chk("d_rst_slot", 32'(d_slot), 32'h1);
    chk("d_rst_vib", 32'(d_vib), 32'd0);
    chk("d_rst_zero", 32'(d_zero), 32'd1);
    chk("d_rst_pg", 32'(d_pg), 32'd0);
    rst_d = 1'b0;
    ticks(7);
    chk("d_pg_s7", 32'(d_pg), 32'd0);
    tick();
    chk("d_slot_8", 32'(d_slot), 32'h00100);
    chk("d_pg_s8", 32'(d_pg), 32'd1);
    tick();
    chk("d_pg_s9", 32'(d_pg), 32'd0);
    ticks(2);
    chk("d_pg_s11", 32'(d_pg), 32'd1);
    chk("d_op_s11", 32'(d_op), 32'd1);
    tick();
    chk("d_pg_s12", 32'(d_pg), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
